// File: rtl/counter20_ctrl_if.sv
// Control and display bundle between the push-button front end and the mod-20 sequencer.
// The master drives the buttons and the direction switch; the slave returns the count status.
interface counter20_ctrl_if;
    logic       start;
    logic       stop;
    logic       clear;
    logic       up;
    logic [4:0] state;
    logic       wrap;
    logic       running;

    modport master (
        output start, stop, clear, up,
        input  state, wrap, running
    );

    modport slave (
        input  start, stop, clear, up,
        output state, wrap, running
    );
endinterface

// File: rtl/counter20_ctrl.sv
// Mod-(MAXCNT+1) up/down display counter stepping once per DIV clocks.
// Start, stop and clear are rising-edge buttons; clear has priority, then stop, then start.
module counter20_ctrl #(
    parameter int DIV    = 50000000,
    parameter int MAXCNT = 19
) (
    input  logic             clk,
    input  logic             rst,
    counter20_ctrl_if.slave  bus
);

    localparam int         PW       = $clog2(DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [4:0] MAX5     = 5'(MAXCNT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE
    } fsm_t;

    fsm_t          r_fsm;
    logic [4:0]    r_count;
    logic [PW-1:0] r_pre;
    logic          r_wrap;
    logic          r_running;
    logic          r_start_prev;
    logic          r_stop_prev;
    logic          r_clear_prev;

    logic          w_start_edge;
    logic          w_stop_edge;
    logic          w_clear_edge;
    logic          w_tick;
    logic [4:0]    w_next_count;
    logic          w_wrap_evt;

    assign w_start_edge = bus.start & ~r_start_prev;
    assign w_stop_edge  = bus.stop  & ~r_stop_prev;
    assign w_clear_edge = bus.clear & ~r_clear_prev;
    assign w_tick       = (r_pre == PRE_LAST);

    // Count value and wrap flag that a tick in this cycle would produce.
    always_comb begin
        w_next_count = r_count;
        w_wrap_evt   = 1'b0;
        if (bus.up) begin
            if (r_count >= MAX5) begin
                w_next_count = 5'd0;
                w_wrap_evt   = 1'b1;
            end else begin
                w_next_count = r_count + 5'd1;
            end
        end else begin
            if (r_count == 5'd0) begin
                w_next_count = MAX5;
                w_wrap_evt   = 1'b1;
            end else begin
                w_next_count = r_count - 5'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm        <= S_IDLE;
            r_count      <= 5'd0;
            r_pre        <= '0;
            r_wrap       <= 1'b0;
            r_running    <= 1'b0;
            r_start_prev <= 1'b0;
            r_stop_prev  <= 1'b0;
            r_clear_prev <= 1'b0;
        end else begin
            r_start_prev <= bus.start;
            r_stop_prev  <= bus.stop;
            r_clear_prev <= bus.clear;
            r_wrap       <= 1'b0;

            if (w_clear_edge) begin
                r_fsm     <= S_IDLE;
                r_count   <= 5'd0;
                r_pre     <= '0;
                r_running <= 1'b0;
            end else begin
                case (r_fsm)
                    S_IDLE: begin
                        r_count <= 5'd0;
                        r_pre   <= '0;
                        if (w_start_edge && !w_stop_edge) begin
                            r_fsm     <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        // A step landing on the same edge as stop is still taken.
                        if (w_tick) begin
                            r_pre   <= '0;
                            r_count <= w_next_count;
                            r_wrap  <= w_wrap_evt;
                        end else begin
                            r_pre <= r_pre + PW'(1);
                        end
                        if (w_stop_edge) begin
                            r_fsm     <= S_PAUSE;
                            r_running <= 1'b0;
                        end
                    end
                    S_PAUSE: begin
                        if (w_start_edge && !w_stop_edge) begin
                            r_fsm     <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    default: begin
                        r_fsm     <= S_IDLE;
                        r_running <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.state   = r_count;
    assign bus.wrap    = r_wrap;
    assign bus.running = r_running;

endmodule

// File: tb/tb_counter20_ctrl.sv
// Scoreboard bench for counter20_ctrl: a reference model queues expected outputs at each rising
// edge, and they are compared on the falling edge; directed checks cover the key scenarios.
module tb_counter20_ctrl;

    localparam int DIV    = 4;
    localparam int MAXCNT = 19;

    typedef struct packed {
        logic [4:0] s;
        logic       w;
        logic       r;
    } exp_t;

    logic clk;
    logic rst;
    counter20_ctrl_if bus_if ();

    counter20_ctrl #(.DIV(DIV), .MAXCNT(MAXCNT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int   n_cmp;
    int   n_err;
    exp_t exp_q[$];

    // Reference model state
    int   m_fsm;
    int   m_cnt;
    int   m_pre;
    bit   m_wrap;
    bit   m_ps;
    bit   m_pt;
    bit   m_pc;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    task automatic model_reset();
        m_fsm  = 0;
        m_cnt  = 0;
        m_pre  = 0;
        m_wrap = 1'b0;
        m_ps   = 1'b0;
        m_pt   = 1'b0;
        m_pc   = 1'b0;
    endtask

    task automatic model_step();
        bit se, te, ce;
        exp_t e;
        se = bus_if.start & ~m_ps;
        te = bus_if.stop  & ~m_pt;
        ce = bus_if.clear & ~m_pc;
        m_ps   = bus_if.start;
        m_pt   = bus_if.stop;
        m_pc   = bus_if.clear;
        m_wrap = 1'b0;
        if (ce) begin
            m_fsm = 0;
            m_cnt = 0;
            m_pre = 0;
        end else if (m_fsm == 0) begin
            if (se && !te) m_fsm = 1;
        end else if (m_fsm == 1) begin
            if (m_pre == DIV - 1) begin
                m_pre = 0;
                if (bus_if.up) begin
                    m_wrap = (m_cnt == MAXCNT);
                    m_cnt  = m_wrap ? 0 : m_cnt + 1;
                end else begin
                    m_wrap = (m_cnt == 0);
                    m_cnt  = m_wrap ? MAXCNT : m_cnt - 1;
                end
            end else begin
                m_pre = m_pre + 1;
            end
            if (te) m_fsm = 2;
        end else begin
            if (se && !te) m_fsm = 1;
        end
        e.s = 5'(m_cnt);
        e.w = m_wrap;
        e.r = (m_fsm == 1);
        exp_q.push_back(e);
    endtask

    // Model: produce the expected outputs for every rising edge.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                model_reset();
                exp_q.push_back(exp_t'(0));
            end else begin
                model_step();
            end
        end
    end

    // Checker: compare DUT outputs against queued expectations, one line per transaction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                $display("[%0t] state=%0d wrap=%0d running=%0d (exp %0d/%0d/%0d)",
                         $time, bus_if.state, bus_if.wrap, bus_if.running, e.s, e.w, e.r);
                chk("sb_state",   32'(bus_if.state),   32'(e.s));
                chk("sb_wrap",    32'(bus_if.wrap),    32'(e.w));
                chk("sb_running", 32'(bus_if.running), 32'(e.r));
            end
        end
    end

    task automatic pulse_start();
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
    endtask

    task automatic pulse_stop();
        bus_if.stop = 1'b1;
        @(negedge clk);
        bus_if.stop = 1'b0;
    endtask

    task automatic wait_state(input logic [4:0] tgt, input int budget, output int cycles);
        cycles = 0;
        while (bus_if.state !== tgt && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        chk("reach_state", 32'(bus_if.state), 32'(tgt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        n_cmp = 0;
        n_err = 0;
        rst          = 1'b1;
        bus_if.start = 1'b0;
        bus_if.stop  = 1'b0;
        bus_if.clear = 1'b0;
        bus_if.up    = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle for 50 clocks
        repeat (50) @(negedge clk);
        chk("idle_state",   32'(bus_if.state),   0);
        chk("idle_running", 32'(bus_if.running), 0);

        // Count up from start, first step after DIV clocks
        pulse_start();
        chk("start_running", 32'(bus_if.running), 1);
        chk("start_state",   32'(bus_if.state),   0);
        wait_state(5'd1, 20, cyc);
        chk("first_step_lat", cyc, DIV);
        wait_state(5'd19, 200, cyc);
        wait_state(5'd0, 20, cyc);
        chk("wrap_up_lat", cyc, DIV);
        chk("wrap_up_pulse", 32'(bus_if.wrap), 1);
        @(negedge clk);
        chk("wrap_up_clear", 32'(bus_if.wrap), 0);

        // Count down through 0
        bus_if.up = 1'b0;
        wait_state(5'd19, 20, cyc);
        chk("wrap_dn_lat", cyc, DIV - 1);
        chk("wrap_dn_pulse", 32'(bus_if.wrap), 1);
        wait_state(5'd18, 20, cyc);
        chk("dn_step_lat", cyc, DIV);
        chk("dn_no_wrap", 32'(bus_if.wrap), 0);

        // Pause one clock before a tick, then resume
        bus_if.up = 1'b1;
        wait_state(5'd7, 100, cyc);
        repeat (2) @(negedge clk);
        pulse_stop();
        chk("pause_running", 32'(bus_if.running), 0);
        chk("pause_state",   32'(bus_if.state),   7);
        repeat (20) @(negedge clk);
        chk("pause_hold", 32'(bus_if.state), 7);
        pulse_start();
        chk("resume_running", 32'(bus_if.running), 1);
        chk("resume_state",   32'(bus_if.state),   7);
        @(negedge clk);
        chk("resume_step", 32'(bus_if.state), 8);

        // Clear and start together on a tick edge
        wait_state(5'd12, 40, cyc);
        repeat (3) @(negedge clk);
        bus_if.clear = 1'b1;
        bus_if.start = 1'b1;
        @(negedge clk);
        bus_if.clear = 1'b0;
        bus_if.start = 1'b0;
        chk("clear_state",   32'(bus_if.state),   0);
        chk("clear_running", 32'(bus_if.running), 0);
        chk("clear_wrap",    32'(bus_if.wrap),    0);
        repeat (10) @(negedge clk);
        chk("clear_idle", 32'(bus_if.state), 0);

        // Asynchronous reset between edges mid-count
        pulse_start();
        wait_state(5'd15, 100, cyc);
        #1 rst = 1'b1;
        #1;
        chk("arst_state",   32'(bus_if.state),   0);
        chk("arst_running", 32'(bus_if.running), 0);
        chk("arst_wrap",    32'(bus_if.wrap),    0);
        model_reset();
        exp_q.delete();
        #2 rst = 1'b0;
        @(negedge clk);
        repeat (20) @(negedge clk);
        chk("post_rst_state",   32'(bus_if.state),   0);
        chk("post_rst_running", 32'(bus_if.running), 0);
        pulse_start();
        chk("restart_running", 32'(bus_if.running), 1);
        wait_state(5'd1, 20, cyc);
        chk("restart_lat", cyc, DIV);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter20_ctrl.md
Name: counter20_ctrl

Overview:
Sequencer for the mod-20 display counter. Produces the 5-bit count (0..19) that drives the two-digit 7-segment decoder, advancing it once per prescaled tick. Start/stop/clear buttons and an up/down select control it. Sits between the board push-buttons/switches and the combinational LED decoder.

Parameters:
DIV, 50000000, clk cycles per count step (>=2); benches use DIV=4
MAXCNT, 19, terminal count value; fixed 5-bit count width, MAXCNT <= 31

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous reset, active-high
start  in  1  level button; rising edge starts or resumes counting
stop  in  1  level button; rising edge pauses counting
clear  in  1  level button; rising edge zeroes count and returns to IDLE
up  in  1  direction: 1 = count up, 0 = count down; sampled on each tick
state  out  5  current count 0..MAXCNT, to the LED decoder
wrap  out  1  one-cycle pulse when count wraps (MAXCNT->0 up, 0->MAXCNT down)
running  out  1  1 while FSM in RUN

Behaviour:
- Reset (async, rst=1): FSM=IDLE, state=0, prescaler=0, wrap=0, running=0, button history regs=0.
- Button edges: each of start/stop/clear registered once; edge = in & ~prev. A button held high through reset release yields one edge on the first clock after release.
- FSM states: IDLE, RUN, PAUSE.
  - IDLE: state held at 0; prescaler held at 0. start edge -> RUN.
  - RUN: prescaler increments each clk; at prescaler==DIV-1 it returns to 0 and a tick occurs that same cycle. stop edge -> PAUSE.
  - PAUSE: state and prescaler frozen. start edge -> RUN, prescaler continues from frozen value.
  - clear edge in any state -> IDLE, state=0, prescaler=0 on the next edge.
- Priority in one cycle: clear > stop > start. start edge while already in RUN: ignored. stop edge in IDLE: ignored.
- Tick (RUN only): up=1: state==MAXCNT -> 0 with wrap=1, else state+1. up=0: state==0 -> MAXCNT with wrap=1, else state-1.
- Tick coincident with stop edge: count step applied, then PAUSE. Tick coincident with clear edge: clear wins, no step, wrap=0.
- wrap registered, asserted for exactly the cycle in which state shows the wrapped value; 0 otherwise.
- running registered: 1 exactly while FSM==RUN.
- Latency: start edge sampled at clock k -> running=1 after k. First step DIV clocks after entering RUN from IDLE.
- state never leaves 0..MAXCNT, including direction changes mid-run and at wrap boundaries.
- Reset mid-count: all outputs return to reset values immediately, independent of clk.

Test Plan:
- Reset, then no buttons for 50 clks -> state=0, running=0, wrap=0 throughout.
- DIV=4, up=1, start pulse -> running=1 next clk; state steps 0,1,2.. every 4 clks; after 19 the next tick gives state=0 with wrap=1 for one clk only.
- Up=0 from state=0 in RUN -> next tick state=19, wrap=1; following tick state=18, wrap=0.
- RUN at state=7, stop pulse 1 clk before tick -> state stays 7 for 20 clks; start pulse -> state=8 after the remaining prescaler count (1 clk), not 4.
- State=12 in RUN, clear and start edges same cycle -> next clk state=0, running=0, FSM IDLE; no step occurs.
- Assert rst for 3 ns mid-count at state=15 between clock edges -> state=0, running=0 immediately; counting resumes only after a new start edge.
